junctions_r_demux_queue: RTL and testbench

- Downstream stage of the 4-way read-response peeking arbiter.
- Buffers the arbitrated AXI-style R beat stream (resp, data, last, id, user) in a small FIFO.
- Routes each beat to one of 4 master-side outputs, selected by two bits of the id.
- Decouples arbiter ready from master back-pressure; keeps sticky error and beat/burst statistics.

---
 rtl/junctions_r_demux_queue.sv | 158 +++++++++++++++
 tb/tb_junctions_r_demux_queue.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/junctions_r_demux_queue.sv
// junctions_r_demux_queue
//   Buffers the arbitrated R beat stream in a DEPTH-entry circular FIFO and
//   steers the head beat to one of four master outputs, chosen by
//   id[ROUTE_LSB+1:ROUTE_LSB]. Strict FIFO order across all outputs, so a
//   stalled head blocks beats for other masters. Delivery statistics
//   (beat count, burst count, sticky error) update on pop.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   io_in_*               : upstream valid/ready + beat fields
//   io_out_N_*            : per-master valid/ready + head-entry fields (N=0..3)
//   io_err_seen           : sticky, set when a beat with resp[1]=1 is delivered
//   io_beat_count         : delivered beats (wraps)
//   io_burst_count        : delivered beats with last=1 (wraps)
module junctions_r_demux_queue #(
  parameter int DEPTH     = 4,
  parameter int ROUTE_LSB = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        io_in_ready,
  input  logic        io_in_valid,
  input  logic [1:0]  io_in_bits_resp,
  input  logic [63:0] io_in_bits_data,
  input  logic        io_in_bits_last,
  input  logic [5:0]  io_in_bits_id,
  input  logic        io_in_bits_user,
  input  logic        io_out_0_ready,
  output logic        io_out_0_valid,
  output logic [1:0]  io_out_0_bits_resp,
  output logic [63:0] io_out_0_bits_data,
  output logic        io_out_0_bits_last,
  output logic [5:0]  io_out_0_bits_id,
  output logic        io_out_0_bits_user,
  input  logic        io_out_1_ready,
  output logic        io_out_1_valid,
  output logic [1:0]  io_out_1_bits_resp,
  output logic [63:0] io_out_1_bits_data,
  output logic        io_out_1_bits_last,
  output logic [5:0]  io_out_1_bits_id,
  output logic        io_out_1_bits_user,
  input  logic        io_out_2_ready,
  output logic        io_out_2_valid,
  output logic [1:0]  io_out_2_bits_resp,
  output logic [63:0] io_out_2_bits_data,
  output logic        io_out_2_bits_last,
  output logic [5:0]  io_out_2_bits_id,
  output logic        io_out_2_bits_user,
  input  logic        io_out_3_ready,
  output logic        io_out_3_valid,
  output logic [1:0]  io_out_3_bits_resp,
  output logic [63:0] io_out_3_bits_data,
  output logic        io_out_3_bits_last,
  output logic [5:0]  io_out_3_bits_id,
  output logic        io_out_3_bits_user,
  output logic        io_err_seen,
  output logic [15:0] io_beat_count,
  output logic [15:0] io_burst_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [1:0]  resp;
    logic [63:0] data;
    logic        last;
    logic [5:0]  id;
    logic        user;
  } beat_t;

  beat_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_err_seen;
  logic [15:0]   r_beat_count, r_burst_count;

  beat_t       w_head;
  logic [1:0]  w_route;
  logic [3:0]  w_out_valid, w_out_ready;
  logic        w_push, w_pop;

  assign w_head  = r_mem[r_rd_ptr];
  assign w_route = w_head.id[ROUTE_LSB+1:ROUTE_LSB];

  // Ready depends only on registered occupancy: when full, a same-cycle pop
  // does not open a slot until the next cycle.
  assign io_in_ready = (r_count != L_FULL);
  assign w_push      = io_in_valid & io_in_ready;

  assign w_out_valid = (r_count != '0) ? (4'b0001 << w_route) : 4'b0000;
  assign w_out_ready = {io_out_3_ready, io_out_2_ready, io_out_1_ready, io_out_0_ready};
  // Only the selected output's ready matters since at most one valid is high.
  assign w_pop       = |(w_out_valid & w_out_ready);

  // Entry storage is not reset; stale contents are never visible because
  // valid is gated by the count.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= '{resp: io_in_bits_resp, data: io_in_bits_data,
                           last: io_in_bits_last, id: io_in_bits_id,
                           user: io_in_bits_user};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_err_seen    <= 1'b0;
      r_beat_count  <= '0;
      r_burst_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_beat_count <= r_beat_count + 16'd1;
        if (w_head.last)    r_burst_count <= r_burst_count + 16'd1;
        if (w_head.resp[1]) r_err_seen    <= 1'b1;
      end
    end
  end

  assign io_err_seen    = r_err_seen;
  assign io_beat_count  = r_beat_count;
  assign io_burst_count = r_burst_count;

  assign io_out_0_valid     = w_out_valid[0];
  assign io_out_0_bits_resp = w_head.resp;
  assign io_out_0_bits_data = w_head.data;
  assign io_out_0_bits_last = w_head.last;
  assign io_out_0_bits_id   = w_head.id;
  assign io_out_0_bits_user = w_head.user;

  assign io_out_1_valid     = w_out_valid[1];
  assign io_out_1_bits_resp = w_head.resp;
  assign io_out_1_bits_data = w_head.data;
  assign io_out_1_bits_last = w_head.last;
  assign io_out_1_bits_id   = w_head.id;
  assign io_out_1_bits_user = w_head.user;

  assign io_out_2_valid     = w_out_valid[2];
  assign io_out_2_bits_resp = w_head.resp;
  assign io_out_2_bits_data = w_head.data;
  assign io_out_2_bits_last = w_head.last;
  assign io_out_2_bits_id   = w_head.id;
  assign io_out_2_bits_user = w_head.user;

  assign io_out_3_valid     = w_out_valid[3];
  assign io_out_3_bits_resp = w_head.resp;
  assign io_out_3_bits_data = w_head.data;
  assign io_out_3_bits_last = w_head.last;
  assign io_out_3_bits_id   = w_head.id;
  assign io_out_3_bits_user = w_head.user;
endmodule

// File: tb/tb_junctions_r_demux_queue.sv
// Bench for junctions_r_demux_queue: directed vector table, hand sequences
// for error/stream/wrap/reset, and random traffic checked against a
// queue-based reference model.
module tb_junctions_r_demux_queue;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0]  resp;
    logic [63:0] data;
    logic        last;
    logic [5:0]  id;
    logic        user;
  } beat_t;

  typedef struct {
    logic        vld;
    logic [5:0]  id;
    logic [63:0] data;
    logic        last;
    logic [3:0]  rdy;
    logic        e_ir;
    logic [3:0]  e_v;
    logic [63:0] e_d;
    logic [15:0] e_beats;
    logic [15:0] e_bursts;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  beat_t in_beat;
  logic in_ready;
  logic [3:0] out_ready;
  logic [3:0] out_valid;
  logic [3:0][1:0]  out_resp;
  logic [3:0][63:0] out_data;
  logic [3:0]       out_last;
  logic [3:0][5:0]  out_id;
  logic [3:0]       out_user;
  logic err_seen;
  logic [15:0] beat_count, burst_count;

  always #5 clk = ~clk;

  junctions_r_demux_queue #(.DEPTH(DEPTH), .ROUTE_LSB(4)) dut (
    .clk(clk), .reset(reset),
    .io_in_ready(in_ready), .io_in_valid(in_valid),
    .io_in_bits_resp(in_beat.resp), .io_in_bits_data(in_beat.data),
    .io_in_bits_last(in_beat.last), .io_in_bits_id(in_beat.id),
    .io_in_bits_user(in_beat.user),
    .io_out_0_ready(out_ready[0]), .io_out_0_valid(out_valid[0]),
    .io_out_0_bits_resp(out_resp[0]), .io_out_0_bits_data(out_data[0]),
    .io_out_0_bits_last(out_last[0]), .io_out_0_bits_id(out_id[0]),
    .io_out_0_bits_user(out_user[0]),
    .io_out_1_ready(out_ready[1]), .io_out_1_valid(out_valid[1]),
    .io_out_1_bits_resp(out_resp[1]), .io_out_1_bits_data(out_data[1]),
    .io_out_1_bits_last(out_last[1]), .io_out_1_bits_id(out_id[1]),
    .io_out_1_bits_user(out_user[1]),
    .io_out_2_ready(out_ready[2]), .io_out_2_valid(out_valid[2]),
    .io_out_2_bits_resp(out_resp[2]), .io_out_2_bits_data(out_data[2]),
    .io_out_2_bits_last(out_last[2]), .io_out_2_bits_id(out_id[2]),
    .io_out_2_bits_user(out_user[2]),
    .io_out_3_ready(out_ready[3]), .io_out_3_valid(out_valid[3]),
    .io_out_3_bits_resp(out_resp[3]), .io_out_3_bits_data(out_data[3]),
    .io_out_3_bits_last(out_last[3]), .io_out_3_bits_id(out_id[3]),
    .io_out_3_bits_user(out_user[3]),
    .io_err_seen(err_seen), .io_beat_count(beat_count),
    .io_burst_count(burst_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: an ordered list of buffered beats plus delivery stats.
  beat_t       mq[$];
  logic [15:0] m_beats, m_bursts;
  logic        m_err;
  logic        g_push, g_pop;

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got %h want %h", name, idx, $time, act, exp);
    end
  endtask

  task automatic do_reset();
    // Push and pop requests held high to confirm reset overrides them.
    reset = 1'b1; in_valid = 1'b1; out_ready = 4'hF;
    in_beat = '{resp: 2'b10, data: 64'hBAD, last: 1'b1, id: 6'h00, user: 1'b0};
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 4'h0;
    mq.delete(); m_beats = '0; m_bursts = '0; m_err = 1'b0;
  endtask

  task automatic sample_and_check();
    logic exp_v;
    @(negedge clk);
    chk("in_ready", 0, 64'(in_ready), 64'(mq.size() != DEPTH));
    for (int n = 0; n < 4; n++) begin
      exp_v = (mq.size() > 0) && (mq[0].id[5:4] == 2'(n));
      chk("valid", n, 64'(out_valid[n]), 64'(exp_v));
      if (mq.size() > 0) begin
        chk("data", n, out_data[n], mq[0].data);
        chk("resp", n, 64'(out_resp[n]), 64'(mq[0].resp));
        chk("last", n, 64'(out_last[n]), 64'(mq[0].last));
        chk("id",   n, 64'(out_id[n]),   64'(mq[0].id));
        chk("user", n, 64'(out_user[n]), 64'(mq[0].user));
      end
    end
    chk("beats",  0, 64'(beat_count),  64'(m_beats));
    chk("bursts", 0, 64'(burst_count), 64'(m_bursts));
    chk("err",    0, 64'(err_seen),    64'(m_err));
    g_pop  = (mq.size() > 0) && out_ready[mq[0].id[5:4]];
    g_push = in_valid && (mq.size() < DEPTH);
  endtask

  task automatic advance();
    beat_t h;
    @(posedge clk);
    if (g_pop) begin
      h = mq.pop_front();
      m_beats = m_beats + 16'd1;
      if (h.last)    m_bursts = m_bursts + 16'd1;
      if (h.resp[1]) m_err = 1'b1;
    end
    if (g_push) mq.push_back(in_beat);
    #1;
  endtask

  task automatic step();
    sample_and_check();
    advance();
  endtask

  function automatic vec_t mk(logic vld, logic [5:0] id, logic [63:0] data, logic last,
                              logic [3:0] rdy, logic e_ir, logic [3:0] e_v, logic [63:0] e_d,
                              logic [15:0] e_beats, logic [15:0] e_bursts);
    vec_t v;
    v.vld = vld; v.id = id; v.data = data; v.last = last; v.rdy = rdy;
    v.e_ir = e_ir; v.e_v = e_v; v.e_d = e_d; v.e_beats = e_beats; v.e_bursts = e_bursts;
    return v;
  endfunction

  vec_t tv[26];

  initial begin
    // single beat to output 2, then pop
    tv[0]  = mk(1, 6'h25, 64'hDEADBEEF00000001, 1, 4'b0000, 1, 4'b0000, 0, 0, 0);
    tv[1]  = mk(0, 0, 0, 0, 4'b0100, 1, 4'b0100, 64'hDEADBEEF00000001, 0, 0);
    tv[2]  = mk(0, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 1, 1);
    // fill to full, then pop while pushing: the push must be dropped
    tv[3]  = mk(1, 6'h00, 64'h10, 0, 4'b0000, 1, 4'b0000, 0,     1, 1);
    tv[4]  = mk(1, 6'h00, 64'h11, 0, 4'b0000, 1, 4'b0001, 64'h10, 1, 1);
    tv[5]  = mk(1, 6'h00, 64'h12, 0, 4'b0000, 1, 4'b0001, 64'h10, 1, 1);
    tv[6]  = mk(1, 6'h00, 64'h13, 0, 4'b0000, 1, 4'b0001, 64'h10, 1, 1);
    tv[7]  = mk(1, 6'h10, 64'h99, 0, 4'b0001, 0, 4'b0001, 64'h10, 1, 1);
    tv[8]  = mk(0, 0, 0, 0, 4'b0000, 1, 4'b0001, 64'h11, 2, 1);
    tv[9]  = mk(0, 0, 0, 0, 4'b1111, 1, 4'b0001, 64'h11, 2, 1);
    tv[10] = mk(0, 0, 0, 0, 4'b1111, 1, 4'b0001, 64'h12, 3, 1);
    tv[11] = mk(0, 0, 0, 0, 4'b1111, 1, 4'b0001, 64'h13, 4, 1);
    tv[12] = mk(0, 0, 0, 0, 4'b1111, 1, 4'b0000, 0, 5, 1);
    // mixed routes, all ready
    tv[13] = mk(1, 6'h00, 64'd1, 0, 4'b1111, 1, 4'b0000, 0,     5, 1);
    tv[14] = mk(1, 6'h10, 64'd2, 0, 4'b1111, 1, 4'b0001, 64'd1, 5, 1);
    tv[15] = mk(1, 6'h20, 64'd3, 0, 4'b1111, 1, 4'b0010, 64'd2, 6, 1);
    tv[16] = mk(1, 6'h30, 64'd4, 0, 4'b1111, 1, 4'b0100, 64'd3, 7, 1);
    tv[17] = mk(0, 0, 0, 0, 4'b1111, 1, 4'b1000, 64'd4, 8, 1);
    tv[18] = mk(0, 0, 0, 0, 4'b1111, 1, 4'b0000, 0, 9, 1);
    // head-of-line blocking: output 0 stalled holds back output 1
    tv[19] = mk(1, 6'h00, 64'd5, 0, 4'b1110, 1, 4'b0000, 0,     9, 1);
    tv[20] = mk(1, 6'h10, 64'd6, 0, 4'b1110, 1, 4'b0001, 64'd5, 9, 1);
    tv[21] = mk(0, 0, 0, 0, 4'b1110, 1, 4'b0001, 64'd5, 9, 1);
    tv[22] = mk(0, 0, 0, 0, 4'b1110, 1, 4'b0001, 64'd5, 9, 1);
    tv[23] = mk(0, 0, 0, 0, 4'b1111, 1, 4'b0001, 64'd5, 9, 1);
    tv[24] = mk(0, 0, 0, 0, 4'b1111, 1, 4'b0010, 64'd6, 10, 1);
    tv[25] = mk(0, 0, 0, 0, 4'b1111, 1, 4'b0000, 0, 11, 1);

    reset = 1'b1; in_valid = 1'b0; out_ready = 4'h0; in_beat = '0;
    do_reset();

    // ---- table-driven vectors
    for (int r = 0; r < 26; r++) begin
      in_valid  = tv[r].vld;
      in_beat   = '{resp: 2'b00, data: tv[r].data, last: tv[r].last, id: tv[r].id, user: 1'b0};
      out_ready = tv[r].rdy;
      sample_and_check();
      chk("tv_in_ready", r, 64'(in_ready),    64'(tv[r].e_ir));
      chk("tv_valid",    r, 64'(out_valid),   64'(tv[r].e_v));
      chk("tv_beats",    r, 64'(beat_count),  64'(tv[r].e_beats));
      chk("tv_bursts",   r, 64'(burst_count), 64'(tv[r].e_bursts));
      for (int n = 0; n < 4; n++)
        if (tv[r].e_v[n]) chk("tv_data", r, out_data[n], tv[r].e_d);
      advance();
    end

    // ---- error beat: err stays low until delivered, then sticky
    do_reset();
    in_valid = 1'b1; out_ready = 4'h0;
    in_beat = '{resp: 2'b10, data: 64'hE, last: 1'b1, id: 6'h10, user: 1'b1};
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("err_held", i, 64'(err_seen), 64'd0);
    end
    out_ready = 4'b0010;
    step();
    chk("err_set", 0, 64'(err_seen), 64'd1);
    out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_beat = '{resp: 2'b00, data: 64'(i), last: 1'b1, id: 6'(i << 4), user: 1'b0};
      step();
      chk("err_sticky", i, 64'(err_seen), 64'd1);
    end
    in_valid = 1'b0;
    step(); step();

    // ---- full-rate stream, 100 beats, 25 bursts of 4
    do_reset();
    out_ready = 4'hF;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_beat = '{resp: 2'b00, data: 64'h5000 + 64'(i), last: (i % 4 == 3),
                  id: 6'(((i % 4) << 4) | (i & 15)), user: 1'(i)};
      sample_and_check();
      if (i > 0) begin
        chk("stream_nobubble", i, 64'(|out_valid), 64'd1);
        chk("stream_data", i, out_data[(i - 1) % 4], 64'h5000 + 64'(i - 1));
      end
      advance();
    end
    in_valid = 1'b0;
    step();
    chk("stream_beats",  0, 64'(beat_count),  64'd100);
    chk("stream_bursts", 0, 64'(burst_count), 64'd25);

    // ---- random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_beat = '{resp: 2'($urandom), data: {$urandom, $urandom}, last: 1'($urandom),
                  id: 6'($urandom), user: 1'($urandom)};
      out_ready = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      step();
    end
    in_valid = 1'b0; out_ready = 4'hF;
    for (int i = 0; i < DEPTH + 1; i++) step();

    // ---- beat counter wrap
    do_reset();
    out_ready = 4'hF;
    in_valid = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      in_beat = '{resp: 2'b00, data: 64'(i), last: 1'b0, id: 6'(i & 6'h3F), user: 1'b0};
      step();
    end
    chk("wrap_ffff", 0, 64'(beat_count), 64'hFFFF);
    in_valid = 1'b0;
    step();
    chk("wrap_zero", 0, 64'(beat_count), 64'h0);

    // ---- reset with 3 buffered beats discards them
    out_ready = 4'h0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_beat = '{resp: 2'b10, data: 64'hA0 + 64'(i), last: 1'b1, id: 6'(i << 4), user: 1'b0};
      step();
    end
    do_reset();
    chk("rst_valid",    0, 64'(out_valid),   64'h0);
    chk("rst_beats",    0, 64'(beat_count),  64'h0);
    chk("rst_bursts",   0, 64'(burst_count), 64'h0);
    chk("rst_err",      0, 64'(err_seen),    64'h0);
    chk("rst_in_ready", 0, 64'(in_ready),    64'h1);
    out_ready = 4'hF;
    step(); step();
    chk("rst_no_deliver", 0, 64'(beat_count), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
